// File: rtl/execute_stage_mc.sv
// Execute stage with operand forwarding, flush, branch/jump resolution and an
// iterative shift-add multiplier (ALUControl 111) that stalls the front end
// through BusyE. Owns the E/M pipeline register.
//
// state | meaning
// IDLE  | single-cycle ops; a multiply start captures operands here
// BUSY  | one shift-add step per cycle, DATA_W steps in total
// DONE  | product is written into E/M on the next edge
module execute_stage_mc #(
  parameter int DATA_W = 19,
  parameter int PC_W   = 15,
  parameter int REG_W  = 5,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              JumpE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic [1:0]        ResultSrcE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1E,
  input  logic [DATA_W-1:0] RD2E,
  input  logic [DATA_W-1:0] ImmExtE,
  input  logic [PC_W-1:0]   PCE,
  input  logic [REG_W-1:0]  RDE,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic              FlushE,
  output logic              PCSrcE,
  output logic [PC_W-1:0]   PCTargetE,
  output logic              BusyE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_W-1:0]  RDM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ALUResultM
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] src_a, fwd_b, src_b, alu_result;
  logic [DATA_W-1:0] mcand, mplier, prod;
  logic [CNT_W-1:0]  cnt;
  logic              is_mul, mul_start, zero;

  // Forwarding muxes; select 11 is reserved and behaves like 00
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : fwd_b;

  // Single-cycle ALU; the multiply result comes from the iterative unit instead
  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      3'b110:  alu_result = src_a << src_b[4:0];
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign is_mul    = (ALUControlE == 3'b111);
  assign PCTargetE = PCE + ImmExtE[PC_W-1:0];
  assign PCSrcE    = ((BranchE & zero) | JumpE) & ~FlushE & ~is_mul;

  // Multiplier sequencing state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and stall output
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    BusyE     = 1'b0;
    case (state)
      IDLE: begin
        mul_start = is_mul && (MUL_EN != 0) && !FlushE;
        BusyE     = mul_start;
        if (mul_start) state_nxt = BUSY;
      end
      BUSY: begin
        BusyE = 1'b1;
        if (FlushE)                            state_nxt = IDLE;
        else if (cnt == CNT_W'(DATA_W - 1))    state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and shift-add datapath; operands never re-read from the muxes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (mul_start) begin
      mcand  <= src_a;
      mplier <= src_b;
      prod   <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // E/M register: flush and stall insert bubbles, DONE writes back the product
  always_ff @(posedge clk or posedge reset) begin
    if (reset || FlushE || BusyE) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RDM        <= '0;
      WriteDataM <= '0;
      ALUResultM <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RDM        <= RDE;
      WriteDataM <= fwd_b;
      ALUResultM <= (state == DONE) ? prod : alu_result;
    end
  end

endmodule
